// File: rtl/thermometer_encoder.sv
// thermometer_encoder: synchronise, debounce and validate a 16-bit thermometer bar into a 0..16 count.
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   LEDs          16-bit thermometer bar, asynchronous to clk, bit 0 = lowest segment
//   current_count accepted count 0..16, registered
//   count_valid   one-cycle strobe when {current_count, code_error} changes
//   code_error    high while the last accepted code was not a legal thermometer code
// Build option: BUBBLE_CORRECT_EN - when defined, an illegal code reports its popcount
//   instead of holding the previous count.
module thermometer_encoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] LEDs,
  output logic [4:0]  current_count,
  output logic        count_valid,
  output logic        code_error
);
  typedef enum logic {LOCKED, SETTLE} state_t;
  state_t      state_q, state_d;
  logic [15:0] s1_q, s2_q, cand_q, cand_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  count_q, count_d, pop, bad_count;
  logic        err_q, err_d, valid_q, valid_d, legal;
  always_comb begin
    pop = '0;
    for (int i = 0; i < 16; i++) pop = pop + 5'(cand_q[i]);
  end
  // 2^k-1 patterns are exactly those with no carry into a set bit when incremented
  assign legal = (({1'b0, cand_q} & ({1'b0, cand_q} + 17'd1)) == 17'd0);
`ifdef BUBBLE_CORRECT_EN
  assign bad_count = pop;
`else
  assign bad_count = count_q;
`endif
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    err_d   = err_q;
    valid_d = 1'b0;
    if (s2_q != cand_q) begin
      cand_d  = s2_q;
      cnt_d   = 8'd1;
      state_d = SETTLE;
    end else if (state_q == SETTLE) begin
      if (cnt_q < 8'(STABLE_CYCLES)) begin
        cnt_d = cnt_q + 8'd1;
      end else begin
        state_d = LOCKED;
        count_d = legal ? pop : bad_count;
        err_d   = !legal;
        valid_d = {count_d, err_d} != {count_q, err_q};
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      state_q <= LOCKED;
      count_q <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s1_q    <= LEDs;
      s2_q    <= s1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end
  assign current_count = count_q;
  assign code_error    = err_q;
  assign count_valid   = valid_q;
endmodule

// File: tb/tb_thermometer_encoder.sv
// tb_thermometer_encoder: directed scoreboard bench for thermometer_encoder.
module tb_thermometer_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] leds = 16'h0000;
  logic [4:0]  current_count;
  logic        count_valid, code_error;
  logic [5:0]  exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  thermometer_encoder #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .LEDs(leds),
    .current_count(current_count), .count_valid(count_valid), .code_error(code_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && count_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {10'd0, current_count, code_error}, 16'hFFFF);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        check("strobe", {10'd0, current_count, code_error}, {10'd0, e});
      end
    end
  end

  task automatic drive(input logic [15:0] v);
    @(negedge clk);
    leds = v;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_count", {11'd0, current_count}, 16'd0);
    check("reset_err", {15'd0, code_error}, 16'd0);
    check("reset_valid", {15'd0, count_valid}, 16'd0);
    settle(50);
    check("idle_count", {11'd0, current_count}, 16'd0);

    // Step to 0x00FF: accept exactly at the 7th edge
    exp_q.push_back({5'd8, 1'b0});
    drive(16'h00FF);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("lat_before_count", {11'd0, current_count}, 16'd0);
    check("lat_before_valid", {15'd0, count_valid}, 16'd0);
    @(posedge clk);
    @(negedge clk);
    check("lat_count", {11'd0, current_count}, 16'd8);
    check("lat_valid", {15'd0, count_valid}, 16'd1);
    settle(1);
    check("pulse_one_cycle", {15'd0, count_valid}, 16'd0);
    settle(10);

    // Full bar and back
    exp_q.push_back({5'd16, 1'b0});
    drive(16'hFFFF);
    settle(12);
    check("full_count", {11'd0, current_count}, 16'd16);
    exp_q.push_back({5'd0, 1'b0});
    drive(16'h0000);
    settle(12);
    check("empty_count", {11'd0, current_count}, 16'd0);

    // Glitch rejection from accepted 0x0007
    exp_q.push_back({5'd3, 1'b0});
    drive(16'h0007);
    settle(12);
    check("seven_count", {11'd0, current_count}, 16'd3);
    drive(16'h000F);
    repeat (2) @(negedge clk);
    leds = 16'h0007;
    settle(15);
    check("glitch_count", {11'd0, current_count}, 16'd3);
    check("glitch_err", {15'd0, code_error}, 16'd0);

    // Illegal code 0x00F7 from count 3
`ifdef BUBBLE_CORRECT_EN
    exp_q.push_back({5'd7, 1'b1});
`else
    exp_q.push_back({5'd3, 1'b1});
`endif
    drive(16'h00F7);
    settle(12);
`ifdef BUBBLE_CORRECT_EN
    check("illegal_count", {11'd0, current_count}, 16'd7);
`else
    check("illegal_count", {11'd0, current_count}, 16'd3);
`endif
    check("illegal_err", {15'd0, code_error}, 16'd1);
    exp_q.push_back({5'd5, 1'b0});
    drive(16'h001F);
    settle(12);
    check("recover_count", {11'd0, current_count}, 16'd5);
    check("recover_err", {15'd0, code_error}, 16'd0);

    // Reset mid-SETTLE
    drive(16'h0003);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_count", {11'd0, current_count}, 16'd0);
    check("midrst_err", {15'd0, code_error}, 16'd0);
    check("midrst_valid", {15'd0, count_valid}, 16'd0);
    settle(2);
    exp_q.push_back({5'd2, 1'b0});
    rst = 1'b0;
    settle(6);
    check("reacq_before", {11'd0, current_count}, 16'd0);
    settle(6);
    check("reacq_count", {11'd0, current_count}, 16'd2);
    settle(5);

    check("pending_strobes", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
